mpu_event_bridge: RTL
=====================

Name: mpu_event_bridge

Overview:
- Fabric-side endpoint of the HPS MPU event interface.
- Drives `hps_0_h2f_mpu_events_eventi`, an SEV-style wake to the A9 cores, with a req/ack handshake and a retry policy when cores remain in WFE.
- Receives `hps_0_h2f_mpu_events_evento` (CPU SEV) as synchronized single-cycle pulses plus a saturating count.
- Sits between the annealer control logic and the `DE1_SOC` system instance in the top level.

Parameters:
- PULSE_W, 4: cycles `eventi` is held high per attempt (legal ≥1).
- RETRY_CYC, 1024: cycles to wait in WAIT for both cores to leave WFE before re-pulsing (legal ≥2).
- MAX_RETRY, 3: re-pulses allowed after the first attempt before failure.
- SYNC_STAGES, 2: flop stages on the async inputs `evento`, `standbywfe`, `standbywfi` (legal ≥2).
- CNT_W, 16: width of `evt_count`.

Ports:
- clk_clk  in  1  system clock; the single clock.
- reset_reset_n  in  1  synchronous, active-low reset.
- evento  in  1  `hps_0_h2f_mpu_events_evento`, asynchronous.
- standbywfe  in  2  per-core WFE standby, asynchronous.
- standbywfi  in  2  per-core WFI standby, asynchronous.
- eventi  out  1  to `hps_0_h2f_mpu_events_eventi`.
- sev_req  in  1  single-cycle request to wake the MPU.
- sev_busy  out  1  high whenever the FSM is not IDLE or a request is pending.
- sev_ack  out  1  1-cycle pulse: event delivered.
- sev_fail  out  1  1-cycle pulse: retries exhausted.
- evt_pulse  out  1  1-cycle pulse per rising edge of `evento`.
- evt_count  out  CNT_W  saturating count of `evento` edges.
- evt_count_clr  in  1  clears `evt_count`.
- wfe_any  out  1  synchronized OR of `standbywfe`.
- wfi_all  out  1  synchronized AND of `standbywfi`.
- evt_ts  out  32  timestamp of last `evt_pulse` (see Optional Feature).

Behaviour:
- Reset (`reset_reset_n`=0 at a clk edge): all outputs 0, FSM=IDLE, pending=0, sync flops=0, counters=0.
- Reset mid-operation aborts the attempt; `eventi` drops at that edge; no ack/fail is issued.
- Sync: `evento`, `standbywfe[1:0]` and `standbywfi[1:0]` each pass through SYNC_STAGES flops. `wfe_any`/`wfi_all` are registered from the synced values.
- Edge detect: `evt_pulse` is high for exactly 1 cycle, SYNC_STAGES+1 edges after the first edge that samples `evento`=1.
  - `evento` held high gives one pulse only.
  - Re-arm requires `evento` low for ≥1 sampled cycle.
- `evt_count`:
  - +1 per `evt_pulse`; saturates at all-ones (no wrap).
  - `evt_count_clr` alone sets it to 0.
  - `evt_count_clr` together with `evt_pulse` sets it to 1.
- Request capture: `sev_req`=1 sets pending. Further requests while pending is set merge (one-deep, no queue).
- FSM states IDLE, PULSE, WAIT:
  - IDLE: if pending, then clear pending, load pulse_cnt=PULSE_W-1, retry=0, go to PULSE. `eventi` is registered high from the same edge.
  - PULSE: `eventi`=1; decrement pulse_cnt. At 0, go to WAIT with timer=0 and `eventi`=0.
  - WAIT, delivered: if synced `standbywfe`==2'b00, pulse `sev_ack` and go to IDLE.
  - WAIT, re-pulse: else if timer==RETRY_CYC-1 and retry<MAX_RETRY, then retry++ and go to PULSE (reload pulse_cnt).
  - WAIT, failure: else if timer==RETRY_CYC-1, pulse `sev_fail` and go to IDLE.
  - WAIT, otherwise: timer++.
- Gap between attempts: `eventi` is low for ≥1 cycle between attempts, so each attempt is a distinct edge at the HPS.
- Total `eventi` pulses per request: ≤ 1+MAX_RETRY.
- `sev_ack` and `sev_fail` are mutually exclusive, with exactly one per launched request.
- Back-to-back requests: a request arriving in the same cycle as ack/fail launches from IDLE on the next edge.
- Minimum ack latency when no core is in WFE: PULSE_W+1 cycles from the IDLE launch edge.

Optional Feature:
- Macro: MPU_EVT_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is added.
  - `evt_ts` loads the counter value in the cycle `evt_pulse` is asserted.
  - `evt_ts` holds until the next pulse.
- Undefined: `evt_ts` is tied to 0 and no counter logic is built.

Test Plan:
- Idle core: `standbywfe`=00, 1-cycle `sev_req` → `eventi` high exactly 4 cycles; `sev_ack` 5 cycles after launch; exactly one ack.
- Stuck WFE: `standbywfe`=01 held, RETRY_CYC=16 → 4 `eventi` pulses separated by low gaps; then `sev_fail` once; `sev_busy` falls.
- Wake on retry: `standbywfe`=10 cleared during the 2nd WAIT → exactly 2 pulses, then `sev_ack`, no `sev_fail`.
- Request merging: 3 `sev_req` pulses during PULSE → one further attempt only; 2 acks total.
- `evento` 1-cycle high ×5, then held high 20 cycles → 6 `evt_pulse`s, each 3 cycles after sampling; `evt_count`=6. With CNT_W=2 saturates at 3. Clr coincident with pulse → 1.
- Reset asserted during PULSE → `eventi`=0 at next edge; no ack/fail; subsequent request behaves as fresh. With MPU_EVT_TIMESTAMP_EN, `evt_ts` equals the cycle index of each `evt_pulse`.

Source files
------------

// File: rtl/mpu_event_bridge.sv
// Fabric-side endpoint of the HPS MPU event interface: SEV wake with retry, CPU event capture.
// Optional build macro MPU_EVT_TIMESTAMP_EN adds a free-running cycle timestamp on evt_ts.
module mpu_event_bridge #(
  parameter int PULSE_W     = 4,
  parameter int RETRY_CYC   = 1024,
  parameter int MAX_RETRY   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             evento,
  input  logic [1:0]       standbywfe,
  input  logic [1:0]       standbywfi,
  output logic             eventi,
  input  logic             sev_req,
  output logic             sev_busy,
  output logic             sev_ack,
  output logic             sev_fail,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] evt_count,
  input  logic             evt_count_clr,
  output logic             wfe_any,
  output logic             wfi_all,
  output logic [31:0]      evt_ts,
  output logic [1:0]       fsm_state_o
);

  localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int TW = $clog2(RETRY_CYC);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PULSE = 2'd1, S_WAIT = 2'd2} state_t;

  logic [SYNC_STAGES-1:0]      evt_sync_q;
  logic [SYNC_STAGES-1:0][1:0] wfe_sync_q;
  logic [SYNC_STAGES-1:0][1:0] wfi_sync_q;
  logic                        evt_prev_q, evt_pulse_q, wfe_any_q, wfi_all_q;
  logic [CNT_W-1:0]            evt_count_q, evt_count_d;
  logic                        evt_rise;
  logic [1:0]                  wfe_synced;

  state_t          state_q;
  logic            pend_q, eventi_q, ack_q, fail_q;
  logic [PW-1:0]   pulse_cnt_q;
  logic [TW-1:0]   timer_q;
  logic [RW-1:0]   retry_q;

  assign evt_rise   = evt_sync_q[SYNC_STAGES-1] & ~evt_prev_q;
  assign wfe_synced = wfe_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      evt_sync_q  <= '0;
      wfe_sync_q  <= '0;
      wfi_sync_q  <= '0;
      evt_prev_q  <= 1'b0;
      evt_pulse_q <= 1'b0;
      wfe_any_q   <= 1'b0;
      wfi_all_q   <= 1'b0;
      evt_count_q <= '0;
    end else begin
      evt_sync_q  <= {evt_sync_q[SYNC_STAGES-2:0], evento};
      wfe_sync_q  <= {wfe_sync_q[SYNC_STAGES-2:0], standbywfe};
      wfi_sync_q  <= {wfi_sync_q[SYNC_STAGES-2:0], standbywfi};
      evt_prev_q  <= evt_sync_q[SYNC_STAGES-1];
      evt_pulse_q <= evt_rise;
      wfe_any_q   <= |wfe_synced;
      wfi_all_q   <= &wfi_sync_q[SYNC_STAGES-1];
      evt_count_q <= evt_count_d;
    end
  end

  // Clear wins over the count, but a pulse in the clear cycle is still counted.
  always_comb begin
    evt_count_d = evt_count_q;
    if (evt_count_clr)
      evt_count_d = evt_pulse_q ? CNT_W'(1) : '0;
    else if (evt_pulse_q && (evt_count_q != '1))
      evt_count_d = evt_count_q + 1'b1;
  end

  // Handshake: sev_req is a 1-cycle strobe captured into a one-deep pending flag;
  // each launched request ends in exactly one sev_ack or sev_fail strobe.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      pulse_cnt_q <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      eventi_q    <= 1'b0;
      ack_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      fail_q <= 1'b0;
      pend_q <= pend_q | sev_req;
      case (state_q)
        S_IDLE: begin
          if (pend_q || sev_req) begin
            pend_q      <= 1'b0;
            pulse_cnt_q <= PW'(PULSE_W - 1);
            retry_q     <= '0;
            eventi_q    <= 1'b1;
            state_q     <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (pulse_cnt_q == '0) begin
            timer_q  <= '0;
            eventi_q <= 1'b0;
            state_q  <= S_WAIT;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 1'b1;
          end
        end
        S_WAIT: begin
          if (wfe_synced == 2'b00) begin
            ack_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (timer_q == TW'(RETRY_CYC - 1)) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_q     <= retry_q + 1'b1;
              pulse_cnt_q <= PW'(PULSE_W - 1);
              eventi_q    <= 1'b1;
              state_q     <= S_PULSE;
            end else begin
              fail_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MPU_EVT_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, evt_ts_q;
  // Loads the counter value that is current while evt_pulse is high.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      ts_cnt_q <= '0;
      evt_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (evt_rise) evt_ts_q <= ts_cnt_q + 32'd1;
    end
  end
  assign evt_ts = evt_ts_q;
`else
  assign evt_ts = '0;
`endif

  assign eventi      = eventi_q;
  assign sev_busy    = (state_q != S_IDLE) | pend_q;
  assign sev_ack     = ack_q;
  assign sev_fail    = fail_q;
  assign evt_pulse   = evt_pulse_q;
  assign evt_count   = evt_count_q;
  assign wfe_any     = wfe_any_q;
  assign wfi_all     = wfi_all_q;
  assign fsm_state_o = state_q;

endmodule
